// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder: FSM state encoding,
// frame field sizes, the read/write command encoding and the CPOL/CPHA
// edge-selection helper used by the input synchronizer.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMMAND    = 3'd1,
    ADDRESS    = 3'd2,
    WRITE_DATA = 3'd3,
    READ_DATA  = 3'd4,
    HOLD       = 3'd5
  } spi_state_e;

  localparam int   COMMAND_BITS = 1;
  localparam logic READ         = 1'b1;

  // Picks the leading or trailing SCLK edge; leading is rising for CPOL=0.
  function automatic logic pick_edge(input logic cpol, input logic want_leading,
                                     input logic rise, input logic fall);
    logic leading;
    logic trailing;
    if (cpol) begin
      leading  = fall;
      trailing = rise;
    end else begin
      leading  = rise;
      trailing = fall;
    end
    if (want_leading) begin
      return leading;
    end else begin
      return trailing;
    end
  endfunction

endpackage

// File: rtl/spi_slave_input_synchronizer.sv
// Two-flop synchronizers for SCLK, chip select and MOSI, plus registered
// sample/shift strobes derived from the synchronized SCLK according to
// CPOL/CPHA. MOSI is delayed one extra stage so that sample_bit is aligned
// with sample_strobe. selected is the synchronized, inverted chip select.
module spi_slave_input_synchronizer
  import spi_slave_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic clock_polarity,
  input  logic clock_phase,
  input  logic serial_clock,
  input  logic chip_select,
  input  logic serial_in,
  output logic selected,
  output logic sample_strobe,
  output logic shift_strobe,
  output logic sample_bit
);

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, sel_sync_q;
  logic mosi_meta_q, mosi_sync_q, mosi_bit_q;
  logic sample_strobe_q, shift_strobe_q;
  logic sample_strobe_d, shift_strobe_d;
  logic sclk_rise, sclk_fall;

  // Classify the synchronized SCLK transition as a sample or a shift edge.
  always_comb begin
    sclk_rise       = sclk_sync_q & ~sclk_prev_q;
    sclk_fall       = ~sclk_sync_q & sclk_prev_q;
    sample_strobe_d = pick_edge(clock_polarity, ~clock_phase, sclk_rise, sclk_fall);
    shift_strobe_d  = pick_edge(clock_polarity, clock_phase, sclk_rise, sclk_fall);
  end

  // Synchronizer chains and edge-strobe registers; chip select idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta_q     <= 1'b0;
      sclk_sync_q     <= 1'b0;
      sclk_prev_q     <= 1'b0;
      cs_meta_q       <= 1'b1;
      sel_sync_q      <= 1'b0;
      mosi_meta_q     <= 1'b0;
      mosi_sync_q     <= 1'b0;
      mosi_bit_q      <= 1'b0;
      sample_strobe_q <= 1'b0;
      shift_strobe_q  <= 1'b0;
    end else begin
      sclk_meta_q     <= serial_clock;
      sclk_sync_q     <= sclk_meta_q;
      sclk_prev_q     <= sclk_sync_q;
      cs_meta_q       <= chip_select;
      sel_sync_q      <= ~cs_meta_q;
      mosi_meta_q     <= serial_in;
      mosi_sync_q     <= mosi_meta_q;
      mosi_bit_q      <= mosi_sync_q;
      sample_strobe_q <= sample_strobe_d;
      shift_strobe_q  <= shift_strobe_d;
    end
  end

  assign selected      = sel_sync_q;
  assign sample_strobe = sample_strobe_q;
  assign shift_strobe  = shift_strobe_q;
  assign sample_bit    = mosi_bit_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder bridging {read_write, address, data} MSB-first frames onto a
// synchronous register port. Supports all CPOL/CPHA modes.
// Optional feature macro: SPI_SLAVE_BURST_EN -- when defined, the data phase
// repeats per word with address auto-increment and read prefetch; when
// undefined, one data word is transferred and the FSM then parks in HOLD.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clock_polarity,
  input  logic                     clock_phase,
  input  logic                     serial_clock,
  input  logic                     chip_select,
  input  logic                     serial_in,
  output logic                     serial_out,
  output logic                     serial_out_enable,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     read_request,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     busy,
  output logic                     frame_abort
);

  localparam int CNT_W = $clog2(((DATA_WIDTH > ADDRESS_WIDTH) ? DATA_WIDTH : ADDRESS_WIDTH) + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(COMMAND_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic selected_s, sample_strobe_s, shift_strobe_s, sample_bit_s;

  spi_state_e               state_q, state_d;
  logic                     sel_prev_q, sel_prev_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     rw_q, rw_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    shift_in_q, shift_in_d;
  logic [DATA_WIDTH-1:0]    shift_out_q, shift_out_d;
  logic [DATA_WIDTH-1:0]    preload_q, preload_d;
  logic                     capture_q, capture_d;
  logic                     serial_out_q, serial_out_d;
  logic                     write_enable_q, write_enable_d;
  logic [ADDRESS_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic                     read_request_q, read_request_d;
  logic [ADDRESS_WIDTH-1:0] read_address_q, read_address_d;
  logic                     frame_abort_q, frame_abort_d;

  logic [ADDRESS_WIDTH-1:0] addr_shift_s, addr_inc_s;
  logic [DATA_WIDTH-1:0]    word_s;
  logic                     partial_s;

  spi_slave_input_synchronizer u_sync (
    .clock          (clock),
    .reset_n        (reset_n),
    .clock_polarity (clock_polarity),
    .clock_phase    (clock_phase),
    .serial_clock   (serial_clock),
    .chip_select    (chip_select),
    .serial_in      (serial_in),
    .selected       (selected_s),
    .sample_strobe  (sample_strobe_s),
    .shift_strobe   (shift_strobe_s),
    .sample_bit     (sample_bit_s)
  );

  // Frame decode, register-port strobes and MISO shifting.
  always_comb begin
    state_d         = state_q;
    sel_prev_d      = selected_s;
    bit_cnt_d       = bit_cnt_q;
    rw_d            = rw_q;
    addr_d          = addr_q;
    shift_in_d      = shift_in_q;
    shift_out_d     = shift_out_q;
    preload_d       = preload_q;
    capture_d       = read_request_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    read_request_d  = 1'b0;
    read_address_d  = read_address_q;
    frame_abort_d   = 1'b0;
    serial_out_d    = 1'b0;

    addr_shift_s = {addr_q[ADDRESS_WIDTH-2:0], sample_bit_s};
    addr_inc_s   = addr_q + ADDRESS_WIDTH'(1);
    word_s       = {shift_in_q[DATA_WIDTH-2:0], sample_bit_s};
    // Any sampled frame bit without a finished word makes a deselect an abort.
    partial_s    = (state_q == ADDRESS) ||
                   (((state_q == WRITE_DATA) || (state_q == READ_DATA)) && (bit_cnt_q != CNT_ZERO));

    // read_data is valid the cycle after read_request. With CPHA=0 the first
    // bit must be on MISO before the first sample edge, so load it at once.
    if (capture_q) begin
      preload_d = read_data;
      if (clock_phase == 1'b0) begin
        shift_out_d = read_data;
      end else begin
        shift_out_d = shift_out_q;
      end
    end else begin
      preload_d = preload_q;
    end

    if (!selected_s) begin
      // Deselect wins over any SCLK edge seen in the same cycle.
      state_d   = IDLE;
      bit_cnt_d = CNT_ZERO;
      if (partial_s) begin
        frame_abort_d = 1'b1;
      end else begin
        frame_abort_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Start only on a fresh select; a select held across reset is ignored.
          if (!sel_prev_q) begin
            state_d     = COMMAND;
            bit_cnt_d   = CNT_ZERO;
            rw_d        = 1'b0;
            addr_d      = {ADDRESS_WIDTH{1'b0}};
            shift_in_d  = {DATA_WIDTH{1'b0}};
            shift_out_d = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        COMMAND: begin
          if (sample_strobe_s) begin
            rw_d = sample_bit_s;
            if (bit_cnt_q == CMD_LAST) begin
              state_d   = ADDRESS;
              bit_cnt_d = CNT_ZERO;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = COMMAND;
          end
        end
        ADDRESS: begin
          if (sample_strobe_s) begin
            addr_d = addr_shift_s;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_d = CNT_ZERO;
              if (rw_q == READ) begin
                state_d        = READ_DATA;
                read_request_d = 1'b1;
                read_address_d = addr_shift_s;
              end else begin
                state_d = WRITE_DATA;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ADDRESS;
          end
        end
        WRITE_DATA: begin
          if (sample_strobe_s) begin
            shift_in_d = word_s;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d       = CNT_ZERO;
              write_enable_d  = 1'b1;
              write_address_d = addr_q;
              write_data_d    = word_s;
              addr_d          = addr_inc_s;
`ifdef SPI_SLAVE_BURST_EN
              state_d = WRITE_DATA;
`else
              state_d = HOLD;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = WRITE_DATA;
          end
        end
        READ_DATA: begin
          if (sample_strobe_s) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = CNT_ZERO;
`ifdef SPI_SLAVE_BURST_EN
              // Prefetch the next word; the final one of a burst goes unused.
              addr_d         = addr_inc_s;
              read_request_d = 1'b1;
              read_address_d = addr_inc_s;
              state_d        = READ_DATA;
`else
              state_d = HOLD;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end else if (shift_strobe_s) begin
            // CPHA=1 loads a word on its first shift edge; CPHA=0 already
            // holds it, so the shift edge before the word's first sample idles.
            if (clock_phase == 1'b1) begin
              if (bit_cnt_q == CNT_ZERO) begin
                shift_out_d = preload_q;
              end else begin
                shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
              end
            end else begin
              if (bit_cnt_q != CNT_ZERO) begin
                shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
              end else begin
                state_d = READ_DATA;
              end
            end
          end else begin
            state_d = READ_DATA;
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (state_d == READ_DATA) begin
      serial_out_d = shift_out_d[DATA_WIDTH-1];
    end else begin
      serial_out_d = 1'b0;
    end
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      sel_prev_q      <= 1'b1;
      bit_cnt_q       <= CNT_ZERO;
      rw_q            <= 1'b0;
      addr_q          <= {ADDRESS_WIDTH{1'b0}};
      shift_in_q      <= {DATA_WIDTH{1'b0}};
      shift_out_q     <= {DATA_WIDTH{1'b0}};
      preload_q       <= {DATA_WIDTH{1'b0}};
      capture_q       <= 1'b0;
      serial_out_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= {ADDRESS_WIDTH{1'b0}};
      write_data_q    <= {DATA_WIDTH{1'b0}};
      read_request_q  <= 1'b0;
      read_address_q  <= {ADDRESS_WIDTH{1'b0}};
      frame_abort_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_prev_q      <= sel_prev_d;
      bit_cnt_q       <= bit_cnt_d;
      rw_q            <= rw_d;
      addr_q          <= addr_d;
      shift_in_q      <= shift_in_d;
      shift_out_q     <= shift_out_d;
      preload_q       <= preload_d;
      capture_q       <= capture_d;
      serial_out_q    <= serial_out_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      read_request_q  <= read_request_d;
      read_address_q  <= read_address_d;
      frame_abort_q   <= frame_abort_d;
    end
  end

  assign serial_out        = serial_out_q;
  assign serial_out_enable = selected_s;
  assign busy              = selected_s;
  assign write_enable      = write_enable_q;
  assign write_address     = write_address_q;
  assign write_data        = write_data_q;
  assign read_request      = read_request_q;
  assign read_address      = read_address_q;
  assign frame_abort       = frame_abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master drives frames,
// a one-cycle-latency memory answers reads, and a frame-level model predicts
// writes, read requests, received words and aborts.
module tb_spi_slave;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clock_polarity, clock_phase, serial_clock, chip_select, serial_in;
  logic        serial_out, serial_out_enable, write_enable, read_request, busy, frame_abort;
  logic [14:0] write_address, read_address;
  logic [15:0] write_data, read_data;

  logic [15:0] mem [0:32767];
  logic [15:0] tx_words [0:3];
  logic        rx_bits [0:127];
  logic [30:0] wr_log [$];
  logic [14:0] rd_log [$];
  int          abort_cnt;
  int          tests_run = 0;
  int          tests_failed = 0;

  spi_slave dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .clock_polarity    (clock_polarity),
    .clock_phase       (clock_phase),
    .serial_clock      (serial_clock),
    .chip_select       (chip_select),
    .serial_in         (serial_in),
    .serial_out        (serial_out),
    .serial_out_enable (serial_out_enable),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_data        (write_data),
    .read_request      (read_request),
    .read_address      (read_address),
    .read_data         (read_data),
    .busy              (busy),
    .frame_abort       (frame_abort)
  );

  always #5 clock = ~clock;

  // Memory: data valid exactly one cycle after the request, noise otherwise.
  always @(posedge clock) begin
    if (read_request) read_data <= mem[read_address];
    else              read_data <= 16'($urandom);
  end

  // Log every strobe cycle so that stretched pulses show up as extra entries.
  always @(negedge clock) begin
    if (write_enable) wr_log.push_back({write_address, write_data});
    if (read_request) rd_log.push_back(read_address);
    if (frame_abort)  abort_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [63:0] out_vec();
    return {12'h000, serial_out, serial_out_enable, write_enable, read_request, busy,
            frame_abort, write_address, write_data, read_address};
  endfunction

  function automatic logic frame_bit(input logic rw, input logic [14:0] addr, input int i);
    logic [15:0] w;
    if (i == 0) return rw;
    if (i < 16) return addr[15 - i];
    w = tx_words[(i - 16) / 16];
    return w[15 - ((i - 16) % 16)];
  endfunction

  // Word k of the frame as seen on MISO; k = -1 is the command/address slot.
  function automatic logic [15:0] rx_word(input int k);
    logic [15:0] w;
    for (int b = 0; b < 16; b++) w[15 - b] = rx_bits[16 + 16 * k + b];
    return w;
  endfunction

  task automatic run_frame(input logic cpol, input logic cpha, input logic rw,
                           input logic [14:0] addr, input int nb_total, input logic deselect);
    clock_polarity = cpol;
    clock_phase    = cpha;
    serial_clock   = cpol;
    serial_in      = 1'b0;
    wait_cycles(12);
    wr_log.delete();
    rd_log.delete();
    abort_cnt = 0;
    for (int i = 0; i < 128; i++) rx_bits[i] = 1'b0;
    chip_select = 1'b0;
    wait_cycles(HALF);
    for (int i = 0; i < nb_total; i++) begin
      if (!cpha) begin
        serial_in = frame_bit(rw, addr, i);
        wait_cycles(HALF);
        rx_bits[i]   = serial_out;
        serial_clock = ~cpol;
        wait_cycles(HALF);
        serial_clock = cpol;
      end else begin
        serial_clock = ~cpol;
        serial_in    = frame_bit(rw, addr, i);
        wait_cycles(HALF);
        rx_bits[i]   = serial_out;
        serial_clock = cpol;
        wait_cycles(HALF);
      end
    end
    wait_cycles(HALF);
    if (deselect) begin
      chip_select = 1'b1;
      wait_cycles(12);
    end
  endtask

  // Frame-level expectations: whole words complete, a trailing fragment aborts
  // only while words are still being accepted.
  task automatic check_frame(input string tag, input logic rw, input logic [14:0] addr, input int nb_total);
    int nd, full, part, done, exp_abort, exp_req;
    logic [14:0] a;
    nd   = nb_total - 16;
    full = nd / 16;
    part = nd % 16;
`ifdef SPI_SLAVE_BURST_EN
    done      = full;
    exp_abort = (part != 0) ? 1 : 0;
    exp_req   = 1 + full;
`else
    done      = (full > 0) ? 1 : 0;
    exp_abort = (full == 0 && part != 0) ? 1 : 0;
    exp_req   = 1;
`endif
    check_eq($sformatf("%s.abort", tag), 64'(abort_cnt), 64'(exp_abort));
    check_eq($sformatf("%s.miso_hdr", tag), {48'h0, rx_word(-1)}, 64'h0);
    if (rw == 1'b0) begin
      check_eq($sformatf("%s.nwr", tag), 64'(wr_log.size()), 64'(done));
      check_eq($sformatf("%s.nrd", tag), 64'(rd_log.size()), 64'h0);
      if (full > 0) check_eq($sformatf("%s.miso_wr", tag), {48'h0, rx_word(0)}, 64'h0);
      for (int i = 0; i < done && i < wr_log.size(); i++) begin
        a = addr + 15'(i);
        check_eq($sformatf("%s.wr%0d", tag, i), {33'h0, wr_log[i]}, {33'h0, a, tx_words[i]});
      end
    end else begin
      check_eq($sformatf("%s.nwr", tag), 64'(wr_log.size()), 64'h0);
      check_eq($sformatf("%s.nrd", tag), 64'(rd_log.size()), 64'(exp_req));
      for (int i = 0; i < exp_req && i < rd_log.size(); i++) begin
        a = addr + 15'(i);
        check_eq($sformatf("%s.rdaddr%0d", tag, i), {49'h0, rd_log[i]}, {49'h0, a});
      end
      for (int i = 0; i < done; i++) begin
        a = addr + 15'(i);
        check_eq($sformatf("%s.rx%0d", tag, i), {48'h0, rx_word(i)}, {48'h0, mem[a]});
      end
`ifndef SPI_SLAVE_BURST_EN
      if (full > 1) check_eq($sformatf("%s.hold_miso", tag), {48'h0, rx_word(1)}, 64'h0);
`endif
    end
  endtask

  initial begin
    logic        cpol, cpha, rw;
    logic [14:0] addr;
    int          nw, part, nb;

    reset_n        = 1'b0;
    chip_select    = 1'b1;
    serial_clock   = 1'b0;
    serial_in      = 1'b0;
    clock_polarity = 1'b0;
    clock_phase    = 1'b0;
    abort_cnt      = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem[15'h0100 + 15'(i)] = 16'h0100 + 16'(i);
    mem[15'h0010] = 16'hBEEF;

    wait_cycles(5);
    check_eq("reset_outputs", out_vec(), 64'h0);
    reset_n = 1'b1;
    wait_cycles(5);
    check_eq("idle_busy", {63'h0, busy}, 64'h0);

    // Single write, mode 0.
    tx_words[0] = 16'hA5C3;
    run_frame(1'b0, 1'b0, 1'b0, 15'h1111, 32, 1'b1);
    check_frame("wr_m0", 1'b0, 15'h1111, 32);

    // Single read, CPOL=1 CPHA=0.
    run_frame(1'b1, 1'b0, 1'b1, 15'h0010, 32, 1'b1);
    check_frame("rd_m2", 1'b1, 15'h0010, 32);

    // Three write words at the top of the address space, then four read words.
    tx_words[0] = 16'h1357;
    tx_words[1] = 16'h2468;
    tx_words[2] = 16'hC0DE;
    run_frame(1'b0, 1'b0, 1'b0, 15'h7FFF, 16 + 48, 1'b1);
    check_frame("wr_burst", 1'b0, 15'h7FFF, 16 + 48);
    run_frame(1'b0, 1'b0, 1'b1, 15'h0100, 16 + 64, 1'b1);
    check_frame("rd_burst", 1'b1, 15'h0100, 16 + 64);

    // Deselect after 8 data bits, then a clean frame.
    tx_words[0] = 16'hA5C3;
    run_frame(1'b0, 1'b0, 1'b0, 15'h0222, 24, 1'b1);
    check_frame("abort", 1'b0, 15'h0222, 24);
    tx_words[0] = 16'h5A3C;
    run_frame(1'b0, 1'b0, 1'b0, 15'h0222, 32, 1'b1);
    check_frame("after_abort", 1'b0, 15'h0222, 32);

    // Reset in the middle of the address phase.
    run_frame(1'b0, 1'b0, 1'b0, 15'h1234, 8, 1'b0);
    check_eq("busy_mid", {63'h0, busy}, 64'h1);
    reset_n = 1'b0;
    #1;
    check_eq("reset_mid", out_vec(), 64'h0);
    wait_cycles(3);
    chip_select = 1'b1;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(3);
    check_eq("abort_on_reset", 64'(abort_cnt), 64'h0);
    tx_words[0] = 16'h0F0F;
    run_frame(1'b1, 1'b1, 1'b0, 15'h4321, 32, 1'b1);
    check_frame("wr_cpha1", 1'b0, 15'h4321, 32);
    run_frame(1'b0, 1'b1, 1'b1, 15'h0101, 32, 1'b1);
    check_frame("rd_cpha1", 1'b1, 15'h0101, 32);

    // Random modes, directions, addresses, lengths and trailing fragments.
    for (int t = 0; t < 12; t++) begin
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      rw   = 1'($urandom);
      addr = 15'($urandom);
      nw   = $urandom_range(1, 3);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      for (int k = 0; k < 4; k++) tx_words[k] = 16'($urandom);
      nb = 16 + 16 * nw + part;
      run_frame(cpol, cpha, rw, addr, nb, 1'b1);
      check_frame($sformatf("rnd%0d", t), rw, addr, nb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
